// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and field widths for the round-robin AXI read arbiter.
package axi_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'b00,
    ArbIssue = 2'b01,
    ArbData  = 2'b10
  } arb_state_e;

  localparam int unsigned LenWidth   = 32;
  localparam int unsigned SizeWidth  = 3;
  localparam int unsigned BurstWidth = 2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Requester-side and engine-side read buses of the arbiter; slot i uses bits [i*W +: W].
interface axi_read_arbiter_if
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*AXI_AWIDTH-1:0] req_addr;
  logic [NUM_REQ*LenWidth-1:0]   req_len;
  logic [NUM_REQ*SizeWidth-1:0]  req_size;
  logic [NUM_REQ*BurstWidth-1:0] req_burst;
  logic [AXI_DWIDTH-1:0]         req_data;
  logic [NUM_REQ-1:0]            req_data_valid;
  logic [NUM_REQ-1:0]            req_data_ready;

  logic                          m_request_valid;
  logic                          m_request_ready;
  logic [AXI_AWIDTH-1:0]         m_addr;
  logic [LenWidth-1:0]           m_len;
  logic [SizeWidth-1:0]          m_size;
  logic [BurstWidth-1:0]         m_burst;
  logic [AXI_DWIDTH-1:0]         m_data;
  logic                          m_data_valid;
  logic                          m_data_ready;

  // Arbiter view: consumes requests, drives the read engine.
  modport master (
    input  req_valid, req_addr, req_len, req_size, req_burst, req_data_ready,
    input  m_request_ready, m_data, m_data_valid,
    output req_ready, req_data, req_data_valid,
    output m_request_valid, m_addr, m_len, m_size, m_burst, m_data_ready
  );

  // Environment view: requesters plus read engine.
  modport slave (
    output req_valid, req_addr, req_len, req_size, req_burst, req_data_ready,
    output m_request_ready, m_data, m_data_valid,
    input  req_ready, req_data, req_data_valid,
    input  m_request_valid, m_addr, m_len, m_size, m_burst, m_data_ready
  );

endinterface

// File: rtl/axi_read_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module rr_priority_select
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     winner,
  output logic               any_valid
);

  int unsigned idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (!any_valid && req[idx]) begin
        winner    = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read engine among NUM_REQ requesters;
// the grant is held until the final data beat of the granted transfer is accepted.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_read_arbiter_if.master         bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [LenWidth-1:0]  beats_q, beats_d;

  logic [IDW-1:0]       winner;
  logic                 any_valid;

  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_data_valid;
  logic                 m_request_valid;
  logic                 m_data_ready;
  logic [LenWidth-1:0]  len_sel;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_select (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  assign len_sel = bus.req_len[grant_q*LenWidth +: LenWidth];

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    beats_d         = beats_q;
    req_ready       = '0;
    req_data_valid  = '0;
    m_request_valid = 1'b0;
    m_data_ready    = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        if (any_valid) begin
          grant_d = winner;
          state_d = ArbIssue;
        end
      end
      ArbIssue: begin
        m_request_valid = 1'b1;
        if (bus.m_request_ready) begin
          req_ready[grant_q] = 1'b1;
          beats_d            = len_sel;
          state_d            = ArbData;
        end
      end
      ArbData: begin
        req_data_valid[grant_q] = bus.m_data_valid;
        m_data_ready            = bus.req_data_ready[grant_q];
        if (bus.m_data_valid && m_data_ready) begin
          // beats_left counts remaining beats after this one; zero marks the last.
          if (beats_q == '0) begin
            last_d  = grant_q;
            state_d = ArbIdle;
          end else begin
            beats_d = beats_q - 1'b1;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ArbIdle;
      grant_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.req_data_valid  = req_data_valid;
  assign bus.req_data        = bus.m_data;
  assign bus.m_request_valid = m_request_valid;
  assign bus.m_data_ready    = m_data_ready;
  assign bus.m_addr          = bus.req_addr[grant_q*AXI_AWIDTH +: AXI_AWIDTH];
  assign bus.m_len           = len_sel;
  assign bus.m_size          = bus.req_size[grant_q*SizeWidth +: SizeWidth];
  assign bus.m_burst         = bus.req_burst[grant_q*BurstWidth +: BurstWidth];
  assign grant_id            = grant_q;
  assign busy                = (state_q != ArbIdle);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with two requesters and a hand-driven read engine.
module tb_axi_read_arbiter;

  localparam int unsigned NR  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = $clog2(NR);

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] grant_id;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  axi_read_arbiter_if #(.NUM_REQ(NR), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) bus ();

  axi_read_arbiter #(.NUM_REQ(NR), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int slot, input logic [31:0] addr, input logic [31:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bus.req_addr[slot*AW +: AW] = addr;
    bus.req_len[slot*32 +: 32]  = len;
    bus.req_size[slot*3 +: 3]   = size;
    bus.req_burst[slot*2 +: 2]  = burst;
  endtask

  // Wait (bounded) for ISSUE, check the grant, let the request fire.
  task automatic issue(input int slot, input string tag);
    int c = 0;
    logic [NR-1:0] one;
    one = '0;
    one[slot] = 1'b1;
    bus.m_request_ready = 1'b1;
    #1;
    while (!bus.m_request_valid && c < 10) begin
      step();
      c++;
    end
    check({tag, "_mrv"}, 64'(bus.m_request_valid), 64'(1));
    check({tag, "_gid"}, 64'(grant_id), 64'(slot));
    check({tag, "_rdy"}, 64'(bus.req_ready), 64'(one));
    step();
    bus.m_request_ready = 1'b0;
  endtask

  // Stream beats with the engine pausing one cycle every 256 beats.
  task automatic beats(input int slot, input int exp_n, input string tag);
    int n = 0;
    int c = 0;
    logic bad = 1'b0;
    logic [NR-1:0] one;
    one = '0;
    one[slot] = 1'b1;
    bus.req_data_ready = one;
    while (busy && c < exp_n + 20) begin
      bus.m_data_valid = (c % 257) != 256;
      bus.m_data = 32'hD000_0000 + 32'(c);
      #1;
      if ((bus.req_data_valid & ~one) != '0 || bus.req_ready != '0 || bus.m_request_valid)
        bad = 1'b1;
      if (bus.req_data_valid[slot] !== bus.m_data_valid || bus.m_data_ready !== 1'b1)
        bad = 1'b1;
      if (bus.req_data !== 32'hD000_0000 + 32'(c)) bad = 1'b1;
      if (bus.req_data_valid[slot] && bus.m_data_ready) n++;
      step();
      c++;
    end
    bus.m_data_valid = 1'b0;
    check({tag, "_beats"}, 64'(n), 64'(exp_n));
    check({tag, "_route"}, 64'(bad), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    int st;
    logic bad;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.req_size = '0;
    bus.req_burst = '0;
    bus.req_data_ready = '0;
    bus.m_request_ready = 1'b0;
    bus.m_data = '0;
    bus.m_data_valid = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_gid", 64'(grant_id), 64'(0));
    check("rst_mrv", 64'(bus.m_request_valid), 64'(0));
    check("rst_rdy", 64'(bus.req_ready), 64'(0));
    check("rst_dv", 64'(bus.req_data_valid), 64'(0));
    check("rst_mdr", 64'(bus.m_data_ready), 64'(0));
    rst = 1'b0;

    // Single request from slot 0, len 3.
    set_req(0, 32'h0000_1000, 32'd3, 3'd2, 2'd1);
    set_req(1, 32'h0000_2000, 32'd9, 3'd1, 2'd2);
    bus.req_valid = 2'b01;
    step();
    check("single_mrv", 64'(bus.m_request_valid), 64'(1));
    check("single_addr", 64'(bus.m_addr), 64'h1000);
    check("single_len", 64'(bus.m_len), 64'(3));
    check("single_size", 64'(bus.m_size), 64'(2));
    check("single_burst", 64'(bus.m_burst), 64'(1));
    check("single_norun", 64'(bus.req_ready), 64'(0));
    issue(0, "single");
    bus.req_valid = 2'b00;
    beats(0, 4, "single");

    // Simultaneous requests from reset alternate 0,1,0,1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 32'h0000_3000, 32'd0, 3'd2, 2'd1);
    set_req(1, 32'h0000_4000, 32'd0, 3'd2, 2'd1);
    bus.req_valid = 2'b11;
    issue(0, "sim_a");
    beats(0, 1, "sim_a");
    issue(1, "sim_b");
    beats(1, 1, "sim_b");
    issue(0, "sim_c");
    beats(0, 1, "sim_c");
    issue(1, "sim_d");
    bus.req_valid = 2'b00;
    beats(1, 1, "sim_d");

    // Back-pressure: slot 1, len 7, 5-cycle stall after 3 beats.
    set_req(1, 32'h0000_5000, 32'd7, 3'd2, 2'd1);
    bus.req_valid = 2'b10;
    issue(1, "bp");
    bus.req_valid = 2'b00;
    n = 0;
    st = 0;
    bad = 1'b0;
    bus.m_data_valid = 1'b1;
    for (int c = 0; c < 40 && busy; c++) begin
      if (n == 3 && st < 5) begin
        bus.req_data_ready = 2'b00;
        #1;
        st++;
        if (bus.m_data_ready !== 1'b0 || bus.req_data_valid !== 2'b10) bad = 1'b1;
      end else begin
        bus.req_data_ready = 2'b10;
        #1;
      end
      if (bus.req_data_valid[1] && bus.m_data_ready) n++;
      step();
    end
    bus.m_data_valid = 1'b0;
    check("bp_beats", 64'(n), 64'(8));
    check("bp_stall", 64'(st), 64'(5));
    check("bp_hold", 64'(bad), 64'(0));
    check("bp_idle", 64'(busy), 64'(0));

    // Large transfer spanning several engine bursts.
    set_req(0, 32'h0001_0000, 32'd599, 3'd2, 2'd1);
    bus.req_valid = 2'b01;
    issue(0, "large");
    bus.req_valid = 2'b00;
    beats(0, 600, "large");

    // Isolation: slot 1 requests while slot 0 is in DATA.
    set_req(0, 32'h0000_6000, 32'd3, 3'd2, 2'd1);
    bus.req_valid = 2'b01;
    issue(0, "iso0");
    set_req(1, 32'h0000_7000, 32'd1, 3'd2, 2'd1);
    bus.req_valid = 2'b10;
    beats(0, 4, "iso0");
    check("iso_gap_mrv", 64'(bus.m_request_valid), 64'(0));
    step();
    check("iso_issue_mrv", 64'(bus.m_request_valid), 64'(1));
    check("iso_issue_gid", 64'(grant_id), 64'(1));
    check("iso_issue_addr", 64'(bus.m_addr), 64'h7000);
    issue(1, "iso1");
    bus.req_valid = 2'b00;
    beats(1, 2, "iso1");

    // Reset mid-DATA after 2 of 8 beats.
    set_req(0, 32'h0000_8000, 32'd7, 3'd2, 2'd1);
    bus.req_valid = 2'b01;
    issue(0, "mrst");
    bus.req_valid = 2'b00;
    bus.m_data_valid = 1'b1;
    bus.req_data_ready = 2'b01;
    step();
    step();
    check("mrst_busy_pre", 64'(busy), 64'(1));
    rst = 1'b1;
    step();
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_gid", 64'(grant_id), 64'(0));
    check("mrst_mrv", 64'(bus.m_request_valid), 64'(0));
    check("mrst_rdy", 64'(bus.req_ready), 64'(0));
    check("mrst_dv", 64'(bus.req_data_valid), 64'(0));
    check("mrst_mdr", 64'(bus.m_data_ready), 64'(0));
    rst = 1'b0;
    bus.m_data_valid = 1'b0;
    set_req(1, 32'h0000_9000, 32'd2, 3'd2, 2'd1);
    bus.req_valid = 2'b10;
    issue(1, "post");
    bus.req_valid = 2'b00;
    beats(1, 3, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
